multiport_instruction_memory: RTL and testbench

- Parametrised successor to the two-source instruction RAM front end.
- Serves NUM_PORTS requesters (port 0 = loader/MAU, ports 1..N-1 = CPU fetch/data) from one single-port synchronous RAM.
- Round-robin arbitration, byte-enable writes and a registered read path with per-port valid.
- A loader-exclusive mode, selected by `alive`, replaces the old static mux.

---
 rtl/imem_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/multiport_instruction_memory.sv | 144 ++++++++++++++
 tb/tb_multiport_instruction_memory.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants, mode encoding and sizing helper for the multiport instruction memory.
package imem_pkg;

    localparam int IMEM_DATA_W    = 32;
    localparam int IMEM_DEPTH     = 32768;
    localparam int IMEM_NUM_PORTS = 3;
    localparam int LOADER_PORT    = 0;

    typedef enum logic {
        MODE_LOADER = 1'b0,
        MODE_SHARED = 1'b1
    } imem_mode_e;

    // Width needed to index n items; never below 1 so vectors stay legal.
    function automatic int imem_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; in loader mode only the loader port can win.
module rr_arbiter
    import imem_pkg::*;
#(
    parameter int N  = IMEM_NUM_PORTS,
    parameter int PW = imem_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          mask_en_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);

    always_comb begin
        logic found;
        int   p;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        p     = 0;
        if (mask_en_i == MODE_SHARED) begin
            // Scan begins at the pointer and wraps, so the last winner goes to the back.
            for (int k = 0; k < N; k++) begin
                p = int'(ptr_i) + k;
                if (p >= N) p = p - N;
                if (!found && req_i[p]) begin
                    found    = 1'b1;
                    gnt_o[p] = 1'b1;
                    idx_o    = PW'(p);
                end
            end
        end else begin
            gnt_o[LOADER_PORT] = req_i[LOADER_PORT];
            idx_o              = PW'(LOADER_PORT);
        end
    end

endmodule

// File: rtl/multiport_instruction_memory.sv
// N-port front end onto one single-port synchronous RAM with byte enables and 1-cycle reads.
// Optional MEM_RANGE_CHECK_EN suppresses and flags accesses with address bits above the RAM index.
module multiport_instruction_memory
    import imem_pkg::*;
#(
    parameter int NUM_PORTS = IMEM_NUM_PORTS,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alive,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] be,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          err
);

    localparam int IDX_W = imem_idx_w(DEPTH);
    localparam int PW    = imem_idx_w(NUM_PORTS);
    localparam int BE_W  = DATA_W / 8;

    logic [ADDR_W-1:0]    port_addr  [NUM_PORTS];
    logic [DATA_W-1:0]    port_wdata [NUM_PORTS];
    logic [BE_W-1:0]      port_be    [NUM_PORTS];

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q;

    logic                 grant_any;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [BE_W-1:0]      sel_be;
    logic [IDX_W-1:0]     widx;
    logic                 oor;
    logic                 wr_en, rd_en;
    logic                 unused_addr_bits;

    logic [DATA_W-1:0]    mem [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign port_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
            assign port_be[gi]    = be[gi*BE_W +: BE_W];
        end
    endgenerate

    rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
        .req_i     (req),
        .mask_en_i (alive),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx)
    );

    assign gnt       = rst ? '0 : arb_gnt;
    assign grant_any = |gnt;

    // One-hot grant makes an AND-OR mux sufficient for the winning port's request.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = port_addr[i];
                sel_wdata = port_wdata[i];
                sel_be    = port_be[i];
            end
        end
    end

    assign widx             = sel_addr[IDX_W+1:2];
    assign unused_addr_bits = ^sel_addr;

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;
    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign oor = |sel_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= grant_any & oor;
    end
    assign err = err_q;
`else
    assign oor = 1'b0;
    assign err = 1'b0;
`endif

    assign wr_en = grant_any & sel_we & ~oor;
    assign rd_en = grant_any & ~sel_we;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (alive && grant_any) begin
            rr_ptr_d = (arb_idx == PW'(NUM_PORTS - 1)) ? '0 : arb_idx + PW'(1);
        end
        rvalid_d = rd_en ? gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
            if (rd_en) rdata_q <= oor ? '0 : mem[widx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_multiport_instruction_memory.sv
// Scoreboard bench: expected reads queued at grant time, popped when rvalid is sampled.
module tb_multiport_instruction_memory;

    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32768;

    typedef struct {
        logic [N-1:0]  port;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            alive;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*4-1:0]  be;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            err;

    int              checks = 0;
    int              passed = 0;
    int              mptr   = 0;
    logic [DW-1:0]   mmem [int];
    exp_t            sb [$];
    logic [N-1:0]    obs_gnt;

    multiport_instruction_memory #(
        .NUM_PORTS(N), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .alive(alive), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             passed++;
    endtask

    task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] b);
        we[p]          = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        be[p*4 +: 4]   = b;
    endtask

    // One clock: predict and check gnt, update the model, then check the registered outputs.
    task automatic step();
        logic [N-1:0]  eg;
        int            gidx;
        int            idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d, cur;
        logic [3:0]    b;
        logic          oor;
        logic          exp_err;
        exp_t          e;
        eg = '0; gidx = -1; exp_err = 1'b0;
        #1;
        if (!rst) begin
            if (!alive) begin
                if (req[0]) gidx = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (mptr + k) % N;
                    if (gidx < 0 && req[p]) gidx = p;
                end
            end
        end
        if (gidx >= 0) eg[gidx] = 1'b1;
        obs_gnt = gnt;
        check("gnt", gnt, eg);
        if (gidx >= 0) begin
            a   = addr[gidx*AW +: AW];
            d   = wdata[gidx*DW +: DW];
            b   = be[gidx*4 +: 4];
            idx = int'((a >> 2) & (DEPTH - 1));
`ifdef MEM_RANGE_CHECK_EN
            oor = (a >= 32'(DEPTH * 4));
`else
            oor = 1'b0;
`endif
            exp_err = oor;
            if (we[gidx]) begin
                if (!oor) begin
                    cur = mmem.exists(idx) ? mmem[idx] : '0;
                    for (int k = 0; k < 4; k++) if (b[k]) cur[k*8 +: 8] = d[k*8 +: 8];
                    mmem[idx] = cur;
                end
                $display("cycle: port %0d write addr=%08h data=%08h be=%b", gidx, a, d, b);
            end else begin
                e.port = eg;
                e.data = oor ? '0 : mmem[idx];
                sb.push_back(e);
                $display("cycle: port %0d read  addr=%08h expect=%08h", gidx, a, e.data);
            end
            if (alive) mptr = (gidx + 1) % N;
        end
        if (rst) begin
            mptr = 0;
            sb.delete();
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rvalid", rvalid, e.port);
            check("rdata", rdata, e.data);
        end else begin
            check("rvalid_idle", rvalid, '0);
        end
        check("err", err, exp_err);
    endtask

    initial begin
        int           cnt [N];
        logic [N-1:0] one;
        one   = 3'b001;
        rst   = 1'b1; alive = 1'b0; req = '0; we = '0;
        addr  = '0;   wdata = '0;   be  = '0;

        step(); step();
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Loader write and read-back in exclusive mode
        drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); req = 3'b001; step();
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);        step();

        // CPU ports are locked out while alive=0
        drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(2, 1'b0, 32'h10, 32'h0, 4'h0);
        req = 3'b110;
        repeat (5) step();
        alive = 1'b1; step();
        check("first_shared", obs_gnt, 3'b010);
        req = 3'b100; step();
        req = 3'b000; step();

        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 32'(i * 4), 32'hA0A0_0000 | 32'(i), 4'hF);
            req = 3'b001; step();
        end

        // Mode drops back to loader with a read in flight
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0); req = 3'b010; step();
        alive = 1'b0; step();
        alive = 1'b1;

        // Reset while a read is requested
        drive(1, 1'b0, 32'h4, 32'h0, 4'h0); req = 3'b010; rst = 1'b1; step();
        rst = 1'b0; req = 3'b000; step();

        // Continuous round-robin from a freshly reset pointer
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h4, 32'h0, 4'h0);
        drive(2, 1'b0, 32'h8, 32'h0, 4'h0);
        for (int p = 0; p < N; p++) cnt[p] = 0;
        req = 3'b111;
        for (int i = 0; i < 9; i++) begin
            step();
            check("rr_seq", obs_gnt, one << (i % 3));
            for (int p = 0; p < N; p++) cnt[p] += int'(obs_gnt[p]);
        end
        for (int p = 0; p < N; p++) check("fair", cnt[p], 3);
        req = 3'b000;

        // Byte-enable merge
        drive(0, 1'b1, 32'h20, 32'h11223344, 4'hF);    req = 3'b001; step();
        drive(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101); req = 3'b100; step();
        drive(1, 1'b0, 32'h20, 32'h0, 4'h0);           req = 3'b010; step();
        check("be_merge", rdata, 32'h11BB33DD);

        // Read immediately after write to the same word
        drive(1, 1'b1, 32'h40, 32'h5A5A1234, 4'hF); req = 3'b010; step();
        drive(2, 1'b0, 32'h40, 32'h0, 4'h0);        req = 3'b100; step();
        check("raw_fwd", rdata, 32'h5A5A1234);

`ifdef MEM_RANGE_CHECK_EN
        drive(1, 1'b0, 32'h0004_0010, 32'h0, 4'h0); req = 3'b010; step();
        check("oor_rdata", rdata, 32'h0);
        drive(2, 1'b1, 32'h0004_0000, 32'h12345678, 4'hF); req = 3'b100; step();
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0); req = 3'b001; step();
        check("oor_nowrite", rdata, 32'hA0A0_0000);
`else
        drive(1, 1'b1, 32'h0002_0010, 32'hCAFEF00D, 4'hF); req = 3'b010; step();
        drive(2, 1'b0, 32'h10, 32'h0, 4'h0);               req = 3'b100; step();
        check("alias", rdata, 32'hCAFEF00D);
`endif

        req = 3'b000; step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
